// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential execute-stage ALU.
//   alu_op_e    : 4-bit operation encoding (13..15 reserved, produce 0).
//   alu_state_e : control FSM states of alu_seq.
//   ITER_OPS    : operations that run on the iterative mul/div datapath.
//   is_iter_op  : true when an op code belongs to ITER_OPS.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_SLT   = 4'd5,
    OP_SLTU  = 4'd6,
    OP_SLL   = 4'd7,
    OP_SRL   = 4'd8,
    OP_SRA   = 4'd9,
    OP_MUL   = 4'd10,
    OP_DIVU  = 4'd11,
    OP_REMU  = 4'd12,
    OP_RSV13 = 4'd13,
    OP_RSV14 = 4'd14,
    OP_RSV15 = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  localparam int N_ITER_OPS = 3;
  localparam alu_op_e ITER_OPS [N_ITER_OPS] = '{OP_MUL, OP_DIVU, OP_REMU};

  function automatic logic is_iter_op(input logic [3:0] op);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < N_ITER_OPS; i++) begin
      if (op == ITER_OPS[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response bundle between the execute stage and alu_seq.
//   master : requester (drives in_valid/op/a/b and out_ready).
//   slave  : the ALU (drives in_ready, out_valid, result, zero).
//
// Handshake: a request transfers on a rising edge where in_valid & in_ready;
// a result transfers on a rising edge where out_valid & out_ready. A
// requester that has raised in_valid keeps op/a/b stable until the transfer.
// While out_valid is high and out_ready low, result and zero do not change.
// out_ready has no meaning while out_valid is low.
interface alu_seq_if #(parameter int XLEN = 32) ();

  logic            in_valid;
  logic            in_ready;
  logic [3:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, zero
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, zero
  );

endinterface

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: shared iterative datapath for MUL / DIVU / REMU.
//   clk, rst : clock, asynchronous active-high reset.
//   i_start  : load operands and begin (one cycle pulse on accept).
//   i_op     : operation code captured with i_start.
//   i_a, i_b : operands (multiplicand/multiplier or dividend/divisor).
//   o_done   : high in the cycle the XLEN-th step is being taken.
//   o_res    : final result, valid while o_done is high.
// One step per cycle; the result is presented combinationally alongside the
// final step so the caller can register it on that same edge.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic [3:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_done,
  output logic [XLEN-1:0] o_res
);

  localparam int SHW = $clog2(XLEN);

  // r_acc: {high, low}. MUL: partial product high, multiplier shifting out
  // of low. DIVU/REMU: partial remainder high, dividend -> quotient low.
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_opnd;
  logic [SHW-1:0]    r_step;
  logic              r_busy;
  logic              r_is_mul;
  logic              r_is_rem;

  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_next;
  logic [2*XLEN:0]   w_div_sh;
  logic [XLEN+1:0]   w_div_trial;
  logic              w_div_fits;
  logic [2*XLEN-1:0] w_div_next;
  logic [2*XLEN-1:0] w_acc_next;

  always_comb begin
    // Shift-add: add multiplicand when the current multiplier bit is set,
    // keep the carry, then shift the whole accumulator right by one.
    w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} +
                 (r_acc[0] ? {1'b0, r_opnd} : {(XLEN+1){1'b0}});
    w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

    // Restoring divide: shift left, trial-subtract the divisor from the
    // top XLEN+1 bits. Two guard bits so a shifted remainder >= 2^XLEN is
    // not mistaken for a borrow. Divisor 0 always fits, which yields an
    // all-ones quotient and the dividend as remainder.
    w_div_sh    = {r_acc, 1'b0};
    w_div_trial = {1'b0, w_div_sh[2*XLEN:XLEN]} - {2'b00, r_opnd};
    w_div_fits  = ~w_div_trial[XLEN+1];
    w_div_next  = w_div_fits ? {w_div_trial[XLEN-1:0], w_div_sh[XLEN-1:1], 1'b1}
                             : w_div_sh[2*XLEN-1:0];

    w_acc_next  = r_is_mul ? w_mul_next : w_div_next;

    o_done = r_busy && (r_step == SHW'(XLEN - 1));
    o_res  = r_is_rem ? w_acc_next[2*XLEN-1:XLEN] : w_acc_next[XLEN-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc    <= '0;
      r_opnd   <= '0;
      r_step   <= '0;
      r_busy   <= 1'b0;
      r_is_mul <= 1'b0;
      r_is_rem <= 1'b0;
    end else if (i_start) begin
      r_acc    <= {{XLEN{1'b0}}, i_a};
      r_opnd   <= i_b;
      r_step   <= '0;
      r_busy   <= 1'b1;
      r_is_mul <= (i_op == OP_MUL);
      r_is_rem <= (i_op == OP_REMU);
    end else if (r_busy) begin
      r_acc  <= w_acc_next;
      // Wraps back to 0 after the final step.
      r_step <= r_step + 1'b1;
      if (o_done) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked execute-stage ALU with single-cycle and iterative ops.
//   clk, rst    : clock, asynchronous active-high reset.
//   bus         : alu_seq_if.slave (in_valid/in_ready/op/a/b request side,
//                 out_valid/out_ready/result/zero response side).
//   o_dbg_state : current control state, for observation only.
// Single-cycle ops register their result on the accept edge (latency 1).
// MUL/DIVU/REMU occupy XLEN ITER cycles, result appears in cycle XLEN+1.
module alu_seq
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic        clk,
  input  logic        rst,
  alu_seq_if.slave    bus,
  output alu_state_e  o_dbg_state
);

  localparam int SHW = $clog2(XLEN);

  alu_state_e      r_state;
  alu_state_e      w_next_state;
  logic [XLEN-1:0] r_result;

  logic            w_in_ready;
  logic            w_accept;
  logic            w_is_iter;
  logic            w_start_iter;
  logic            w_iter_done;
  logic [XLEN-1:0] w_iter_res;
  logic [XLEN-1:0] w_single_res;
  logic [SHW-1:0]  w_shamt;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_in_ready   = 1'b0;
    w_accept     = 1'b0;
    w_is_iter    = is_iter_op(bus.op);
    w_start_iter = 1'b0;

    // out_ready -> in_ready is the one combinational path: a finishing
    // result frees the slot in the same cycle.
    w_in_ready   = (r_state == ST_IDLE) || ((r_state == ST_DONE) && bus.out_ready);
    w_accept     = bus.in_valid && w_in_ready;
    w_start_iter = w_accept && w_is_iter;

    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_next_state = w_is_iter ? ST_ITER : ST_DONE;
      end
      ST_ITER: begin
        if (w_iter_done) w_next_state = ST_DONE;
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          if (w_accept) w_next_state = w_is_iter ? ST_ITER : ST_DONE;
          else          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // ---------------- single-cycle datapath ----------------
  assign w_shamt = bus.b[SHW-1:0];

  always_comb begin
    w_single_res = '0;
    case (bus.op)
      OP_ADD:  w_single_res = bus.a + bus.b;
      OP_SUB:  w_single_res = bus.a - bus.b;
      OP_AND:  w_single_res = bus.a & bus.b;
      OP_OR:   w_single_res = bus.a | bus.b;
      OP_XOR:  w_single_res = bus.a ^ bus.b;
      OP_SLT:  w_single_res = {{(XLEN-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      OP_SLTU: w_single_res = {{(XLEN-1){1'b0}}, (bus.a < bus.b)};
      OP_SLL:  w_single_res = bus.a << w_shamt;
      OP_SRL:  w_single_res = bus.a >> w_shamt;
      OP_SRA:  w_single_res = $unsigned($signed(bus.a) >>> w_shamt);
      default: w_single_res = '0;
    endcase
  end

  // ---------------- iterative datapath ----------------
  alu_muldiv_iter #(.XLEN(XLEN)) u_muldiv (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_start_iter),
    .i_op    (bus.op),
    .i_a     (bus.a),
    .i_b     (bus.b),
    .o_done  (w_iter_done),
    .o_res   (w_iter_res)
  );

  // ---------------- result register ----------------
  // Only written on a single-cycle accept or on iterative completion, so it
  // holds while a result waits for out_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result <= '0;
    end else if (w_accept && !w_is_iter) begin
      r_result <= w_single_res;
    end else if ((r_state == ST_ITER) && w_iter_done) begin
      r_result <= w_iter_res;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.result    = r_result;
  assign bus.zero      = (r_result == '0);
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
  import alu_pkg::*;

  localparam int XLEN = 32;

  logic       clk;
  logic       rst;
  alu_state_e dbg_state;

  int errors = 0;
  int checks = 0;
  logic [XLEN-1:0] exp_q[$];

  alu_seq_if #(.XLEN(XLEN)) bus ();

  alu_seq #(.XLEN(XLEN)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  function automatic logic [XLEN-1:0] ref_alu(input logic [3:0] op,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
    logic [2*XLEN-1:0] prod;
    int unsigned sh;
    logic signed [XLEN-1:0] sa;
    sh = b % XLEN;
    sa = a;
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return (sa < $signed(b)) ? 1 : 0;
      4'd6:  return (a < b) ? 1 : 0;
      4'd7:  return a << sh;
      4'd8:  return a >> sh;
      4'd9:  return sa >>> sh;
      4'd10: begin prod = a * 64'(b); prod = 64'(a) * 64'(b); return prod[XLEN-1:0]; end
      4'd11: return (b == 0) ? {XLEN{1'b1}} : a / b;
      4'd12: return (b == 0) ? a : a % b;
      default: return '0;
    endcase
  endfunction

  function automatic int ref_latency(input logic [3:0] op);
    return (op >= 4'd10 && op <= 4'd12) ? XLEN + 1 : 1;
  endfunction

  // ---------------- driver ----------------
  // Called at a negedge. Presents one request with out_ready=1, returns the
  // cycle (counted from the accept edge) in which out_valid was seen, plus
  // the result/zero seen then and whether in_ready stayed low while waiting.
  task automatic run_op(input logic [3:0] op, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, output int lat,
                        output logic [XLEN-1:0] res, output logic z,
                        output logic busy_ok);
    int n;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      errors++;
      $display("FAIL run_op_in_ready_timeout: in_ready=%0b after %0d cycles, need 1", bus.in_ready, n);
    end
    bus.in_valid  = 1'b1;
    bus.op        = op;
    bus.a         = a;
    bus.b         = b;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat     = 1;
    busy_ok = 1'b1;
    while (!bus.out_valid && lat < 200) begin
      if (bus.in_ready) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    res = bus.result;
    z   = bus.zero;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op        = 4'd0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
    #1 rst = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b need 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b need 0", bus.out_valid); end
    checks++; if (bus.result !== '0) begin errors++; $display("FAIL reset_result: got %h need 0", bus.result); end
    checks++; if (bus.zero !== 1'b1) begin errors++; $display("FAIL reset_zero: got %0b need 1", bus.zero); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d need IDLE", dbg_state); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_directed();
    logic [3:0]      ops [11] = '{4'd0, 4'd1, 4'd5, 4'd6, 4'd4, 4'd9, 4'd8, 4'd7, 4'd2, 4'd3, 4'd13};
    logic [XLEN-1:0] as  [11] = '{32'h7FFFFFFF, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hF0F0F0F0,
                                  32'h80000000, 32'h80000000, 32'd1, 32'hFF00FF00, 32'h0000F000, 32'd5};
    logic [XLEN-1:0] bs  [11] = '{32'd1, 32'd5, 32'd1, 32'd1, 32'hFFFF0000,
                                  32'h24, 32'h24, 32'd31, 32'h0F0F0F0F, 32'h0000000F, 32'd6};
    logic [XLEN-1:0] ex  [11] = '{32'h80000000, 32'd0, 32'd1, 32'd0, 32'h0F0FF0F0,
                                  32'hF8000000, 32'h08000000, 32'h80000000, 32'h0F000F00, 32'h0000F00F, 32'd0};
    int lat;
    logic [XLEN-1:0] res;
    logic z, busy_ok;
    for (int i = 0; i < 11; i++) begin
      run_op(ops[i], as[i], bs[i], lat, res, z, busy_ok);
      checks++; if (res !== ex[i]) begin errors++; $display("FAIL single_result[%0d] op=%0d: got %h need %h", i, ops[i], res, ex[i]); end
      checks++; if (z !== (ex[i] == '0)) begin errors++; $display("FAIL single_zero[%0d]: got %0b need %0b", i, z, (ex[i] == '0)); end
      checks++; if (lat !== 1) begin errors++; $display("FAIL single_latency[%0d]: got %0d need 1", i, lat); end
    end
  endtask

  task automatic test_muldiv_directed();
    logic [3:0]      ops [5] = '{4'd10, 4'd11, 4'd12, 4'd11, 4'd12};
    logic [XLEN-1:0] as  [5] = '{32'h0000FFFF, 32'd100, 32'd100, 32'd9, 32'd9};
    logic [XLEN-1:0] bs  [5] = '{32'h00010001, 32'd7, 32'd7, 32'd0, 32'd0};
    logic [XLEN-1:0] ex  [5] = '{32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFF, 32'd9};
    int lat;
    logic [XLEN-1:0] res;
    logic z, busy_ok;
    for (int i = 0; i < 5; i++) begin
      run_op(ops[i], as[i], bs[i], lat, res, z, busy_ok);
      checks++; if (res !== ex[i]) begin errors++; $display("FAIL muldiv_result[%0d] op=%0d: got %h need %h", i, ops[i], res, ex[i]); end
      checks++; if (lat !== XLEN + 1) begin errors++; $display("FAIL muldiv_latency[%0d]: got %0d need %0d", i, lat, XLEN + 1); end
      checks++; if (busy_ok !== 1'b1) begin errors++; $display("FAIL muldiv_in_ready_busy[%0d]: in_ready seen high=%0b need 0", i, !busy_ok); end
    end
  endtask

  task automatic test_random();
    int lat;
    logic [3:0] op;
    logic [XLEN-1:0] a, b, res, exp_v;
    logic z, busy_ok;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      exp_q.push_back(ref_alu(op, a, b));
      run_op(op, a, b, lat, res, z, busy_ok);
      exp_v = exp_q.pop_front();
      checks++; if (res !== exp_v) begin errors++; $display("FAIL rand_result[%0d] op=%0d a=%h b=%h: got %h need %h", i, op, a, b, res, exp_v); end
      checks++; if (z !== (exp_v == '0)) begin errors++; $display("FAIL rand_zero[%0d]: got %0b need %0b", i, z, (exp_v == '0)); end
      checks++; if (lat !== ref_latency(op)) begin errors++; $display("FAIL rand_latency[%0d] op=%0d: got %0d need %0d", i, op, lat, ref_latency(op)); end
    end
  endtask

  task automatic test_backpressure();
    logic [XLEN-1:0] exp_v;
    exp_v = ref_alu(4'd0, 32'h10, 32'h20);
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.op        = 4'd0;
    bus.a         = 32'h10;
    bus.b         = 32'h20;
    @(posedge clk);
    @(negedge clk);
    // A competing request that must not be taken while the result waits.
    bus.op = 4'd4;
    bus.a  = 32'hFFFFFFFF;
    bus.b  = 32'h12345678;
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid[%0d]: got %0b need 1", i, bus.out_valid); end
      checks++; if (bus.result !== exp_v) begin errors++; $display("FAIL bp_result[%0d]: got %h need %h", i, bus.result, exp_v); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %0b need 0", i, bus.in_ready); end
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_release: out_valid=%0b need 0", bus.out_valid); end
    checks++; if (bus.result !== exp_v) begin errors++; $display("FAIL bp_release_result: got %h need %h", bus.result, exp_v); end
  endtask

  task automatic test_back_to_back();
    logic [XLEN-1:0] as [4];
    logic [XLEN-1:0] bs [4];
    logic [XLEN-1:0] exp_v;
    for (int i = 0; i < 4; i++) begin
      as[i] = $urandom;
      bs[i] = $urandom;
      exp_q.push_back(as[i] + bs[i]);
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.op        = 4'd0;
    bus.a         = as[0];
    bus.b         = bs[0];
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_out_valid[%0d]: got %0b need 1", i, bus.out_valid); end
      checks++; if (bus.result !== exp_v) begin errors++; $display("FAIL b2b_result[%0d]: got %h need %h", i, bus.result, exp_v); end
      if (i < 3) begin
        bus.a = as[i+1];
        bus.b = bs[i+1];
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: out_valid=%0b need 0", bus.out_valid); end
  endtask

  task automatic test_reset_mid_iter();
    int lat;
    logic [XLEN-1:0] res;
    logic z, busy_ok, spurious;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.op        = 4'd11;
    bus.a         = 32'd1000;
    bus.b         = 32'd3;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    checks++; if (dbg_state !== ST_ITER) begin errors++; $display("FAIL rst_iter_precond: state=%0d need ITER", dbg_state); end
    rst = 1'b1;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_iter_out_valid: got %0b need 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_iter_in_ready: got %0b need 1", bus.in_ready); end
    checks++; if (bus.result !== '0) begin errors++; $display("FAIL rst_iter_result: got %h need 0", bus.result); end
    checks++; if (bus.zero !== 1'b1) begin errors++; $display("FAIL rst_iter_zero: got %0b need 1", bus.zero); end
    @(negedge clk);
    rst = 1'b0;
    spurious = 1'b0;
    for (int i = 0; i < XLEN + 8; i++) begin
      @(negedge clk);
      if (bus.out_valid) spurious = 1'b1;
    end
    checks++; if (spurious !== 1'b0) begin errors++; $display("FAIL rst_iter_spurious: out_valid seen=%0b need 0", spurious); end
    run_op(4'd0, 32'd2, 32'd3, lat, res, z, busy_ok);
    checks++; if (res !== 32'd5) begin errors++; $display("FAIL rst_after_add: got %h need 5", res); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL rst_after_latency: got %0d need 1", lat); end
  endtask

  // ---------------- sequence ----------------
  initial begin
    test_reset();
    test_single_directed();
    test_muldiv_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_iter();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, need completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the single-cycle integer ALU. Adds XOR, signed/unsigned compare, shifts, and iterative multiply / unsigned divide / remainder to the existing add/sub/and/or set. It uses valid/ready on both sides so the execute stage can stall on long operations. It sits in the execute stage between operand read and writeback.

## Interface
- XLEN, 32, operand/result width; legal values 32 or 64.
- SHW, $clog2(XLEN), shift-amount width (derived; not overridden).
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operation request.
- in_ready  out  1  block accepts the request this cycle.
- op  in  4  operation code (alu_pkg encoding).
- a  in  XLEN  operand A.
- b  in  XLEN  operand B.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- result  out  XLEN  registered result.
- zero  out  1  result == 0.

## Operation
- Op codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLT (signed a<b → 1, else 0), 6 SLTU (unsigned compare).
  - 7 SLL, 8 SRL, 9 SRA (amount = b[SHW-1:0]).
  - 10 MUL (low XLEN bits of a*b), 11 DIVU, 12 REMU.
  - 13–15 reserved; result 0, single-cycle.
- Arithmetic is modulo 2^XLEN. There is no overflow flag.
- Divide by zero: DIVU = all ones; REMU = a.
- FSM states:
  - IDLE → DONE on accept of a single-cycle op.
  - IDLE → ITER on accept of MUL/DIVU/REMU.
  - ITER → DONE after XLEN iteration steps.
  - DONE → IDLE on out_ready when there is no new accept.
  - DONE → DONE or ITER on out_ready with a simultaneous accept.
- ITER performs one shift-add (MUL) or one restoring-subtract (DIVU/REMU) step per cycle, tracked by a step counter 0..XLEN-1.
- in_ready = (state==IDLE) | (state==DONE & out_ready).
- Accept = in_valid & in_ready. op/a/b are captured only on accept.
- During ITER, in_valid is ignored and the requester must hold its request.
- While out_valid & !out_ready, result and zero are held stable.
- out_ready is ignored while out_valid is 0.
- zero is derived from the result register.
- Reset values: state IDLE, in_ready 1, out_valid 0, result 0, zero 1, step counter 0.
- Reset asserted in any state, including mid-ITER, aborts the operation with no out_valid pulse. The next accepted op executes normally.

## Timing
- Cycle numbering: the accept edge is e0; the cycle after it is cycle 1.
- Single-cycle ops: result is registered at e0; out_valid=1 in cycle 1 (latency 1).
- Iterative ops: ITER occupies cycles 1..XLEN; out_valid=1 in cycle XLEN+1 (33 for XLEN=32).
- Throughput with out_ready held 1:
  - single-cycle ops back-to-back: one per cycle.
  - iterative ops: one per XLEN+1 cycles.
- No combinational path from a/b/op to result. out_ready → in_ready is the only combinational path.

## Structure
- Package alu_pkg holds:
  - alu_op_e enum, 4 bits, encodings above.
  - alu_state_e (IDLE, ITER, DONE).
  - a helper constant list identifying the iterative ops.
- Sub-module alu_muldiv_iter (parameter XLEN) implements the shared iterative datapath:
  - a 2·XLEN accumulator/remainder register, operand register, and step counter.
  - inputs: start, op, a, b. Outputs: done, res.
  - It raises done on the XLEN-th step.
- Top-level alu_seq holds the FSM, the handshake, the single-cycle datapath, and the result mux/register.

## Test plan
- ADD 0x7FFFFFFF+0x00000001 → result 0x80000000, zero 0, out_valid in cycle 1. SUB 5−5 → 0, zero 1.
- SLT a=0xFFFFFFFF b=1 → 1. SLTU with the same operands → 0. XOR 0xF0F0F0F0^0xFFFF0000 → 0x0F0FF0F0.
- SRA a=0x80000000 b=0x24 (amount 4) → 0xF8000000. SRL with the same operands → 0x08000000. SLL 1 by b=31 → 0x80000000.
- MUL 0x0000FFFF*0x00010001 → 0xFFFFFFFF, with out_valid in cycle 33 and in_ready 0 during cycles 1..32. DIVU 100/7 → 14; REMU 100/7 → 2. DIVU 9/0 → 0xFFFFFFFF; REMU 9/0 → 9.
- Backpressure: hold out_ready 0 for 5 cycles after a result → result stable, in_ready 0. Then 4 back-to-back ADDs with out_ready 1 → 4 results on 4 consecutive cycles, in order.
- Assert rst during step 10 of a DIVU → out_valid 0 and in_ready 1 immediately, result 0, with no spurious completion. A following ADD 2+3 → 5 in cycle 1.
